// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath stages: controller
// state encoding, default fixed-point format and the shift-and-saturate
// helper shared by the convolution and fully-connected layers.
package nn_pkg;

    // Default fixed-point format (Q7.8)
    localparam int NN_WIDTH     = 16;
    localparam int NN_FRAC_BITS = 8;

    // Width of the intermediate sum handed to sat_trunc; callers
    // sign-extend their accumulator sums to this width.
    localparam int NN_WIDE      = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } nn_state_e;

    // Arithmetic right shift by frac (rounds toward -inf), then clamp to
    // the signed range of a width-bit word. The result is returned
    // sign-extended; callers keep the low width bits.
    function automatic logic signed [NN_WIDE-1:0] sat_trunc(
        input logic signed [NN_WIDE-1:0] sum,
        input int                        width,
        input int                        frac
    );
        logic signed [NN_WIDE-1:0] res;
        logic signed [NN_WIDE-1:0] hi;
        logic signed [NN_WIDE-1:0] lo;
        res = sum >>> frac;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (width - 1));
        if (res > hi) begin
            sat_trunc = hi;
        end else if (res < lo) begin
            sat_trunc = lo;
        end else begin
            sat_trunc = res;
        end
    endfunction

endpackage

// File: rtl/conv_layer_mac.sv
// Registered signed multiply-accumulate. Clear wins over enable; the
// accumulator is sized by the caller so that it cannot overflow.
module mac_unit #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 36
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clr,
    input  logic                        i_en,
    input  logic signed [WIDTH-1:0]     i_a,
    input  logic signed [WIDTH-1:0]     i_b,
    output logic signed [ACC_WIDTH-1:0] o_acc
);

    localparam int PW  = 2 * WIDTH;
    localparam int EXT = ACC_WIDTH - PW;

    logic signed [PW-1:0]        w_a_ext;
    logic signed [PW-1:0]        w_b_ext;
    logic signed [PW-1:0]        w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] r_acc;

    // Full-precision signed product, sign-extended to accumulator width
    always_comb begin
        w_a_ext    = {{WIDTH{i_a[WIDTH-1]}}, i_a};
        w_b_ext    = {{WIDTH{i_b[WIDTH-1]}}, i_b};
        w_prod     = w_a_ext * w_b_ext;
        w_prod_ext = {{EXT{w_prod[PW-1]}}, w_prod};
    end

    // Accumulator register: clear, accumulate or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conv_layer.sv
// Sequential single-channel valid convolution (stride 1, scalar bias).
// One MAC per cycle; output positions are visited in row-major order and
// each result is biased, truncated, saturated and registered in place.
module conv_layer
    import nn_pkg::*;
#(
    parameter int WIDTH             = NN_WIDTH,
    parameter int FRAC_BITS         = NN_FRAC_BITS,
    parameter int INPUT_DIM_WIDTH   = 4,
    parameter int INPUT_DIM_HEIGHT  = 4,
    parameter int KERNEL_SIZE       = 3,
    parameter int OUTPUT_DIM_WIDTH  = INPUT_DIM_WIDTH - KERNEL_SIZE + 1,
    parameter int OUTPUT_DIM_HEIGHT = INPUT_DIM_HEIGHT - KERNEL_SIZE + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] input_feature_map  [0:INPUT_DIM_HEIGHT-1][0:INPUT_DIM_WIDTH-1],
    input  logic signed [WIDTH-1:0] kernel             [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    input  logic signed [WIDTH-1:0] bias,
    output logic signed [WIDTH-1:0] output_feature_map [0:OUTPUT_DIM_HEIGHT-1][0:OUTPUT_DIM_WIDTH-1],
    output logic                    busy,
    output logic                    done
);

    localparam int ACC_WIDTH = 2 * WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE);
    localparam int RW = (INPUT_DIM_HEIGHT > 1) ? $clog2(INPUT_DIM_HEIGHT) : 1;
    localparam int CW = (INPUT_DIM_WIDTH  > 1) ? $clog2(INPUT_DIM_WIDTH)  : 1;

    nn_state_e r_state;
    logic [RW-1:0] r_oy;
    logic [RW-1:0] r_ky;
    logic [CW-1:0] r_ox;
    logic [CW-1:0] r_kx;
    logic          r_busy;
    logic          r_done;

    logic signed [WIDTH-1:0] r_in   [0:INPUT_DIM_HEIGHT-1][0:INPUT_DIM_WIDTH-1];
    logic signed [WIDTH-1:0] r_k    [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];
    logic signed [WIDTH-1:0] r_bias;
    logic signed [WIDTH-1:0] r_ofm  [0:OUTPUT_DIM_HEIGHT-1][0:OUTPUT_DIM_WIDTH-1];

    logic [RW-1:0]               w_row;
    logic [CW-1:0]               w_col;
    logic signed [WIDTH-1:0]     w_a;
    logic signed [WIDTH-1:0]     w_b;
    logic                        w_clr;
    logic                        w_en;
    logic signed [ACC_WIDTH-1:0] w_acc;
    logic signed [NN_WIDE-1:0]   w_acc64;
    logic signed [NN_WIDE-1:0]   w_bias64;
    logic signed [NN_WIDE-1:0]   w_sum64;
    logic signed [NN_WIDE-1:0]   w_sat64;
    logic signed [WIDTH-1:0]     w_res;
    logic                        w_unused_hi;

    // Operand selection for the current tap and MAC control decode
    always_comb begin
        w_row = r_oy + r_ky;
        w_col = r_ox + r_kx;
        w_a   = r_in[w_row][w_col];
        w_b   = r_k[r_ky][r_kx];
        w_en  = 1'b0;
        w_clr = 1'b0;
        if (r_state == MAC) begin
            w_en = 1'b1;
        end else begin
            w_en = 1'b0;
        end
        if (((r_state == IDLE) && start) || (r_state == WRITE)) begin
            w_clr = 1'b1;
        end else begin
            w_clr = 1'b0;
        end
    end

    mac_unit #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (w_clr),
        .i_en  (w_en),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_acc (w_acc)
    );

    // Bias alignment, truncating shift and saturation of the finished sum
    always_comb begin
        w_acc64     = {{(NN_WIDE-ACC_WIDTH){w_acc[ACC_WIDTH-1]}}, w_acc};
        w_bias64    = {{(NN_WIDE-WIDTH){r_bias[WIDTH-1]}}, r_bias};
        w_sum64     = w_acc64 + (w_bias64 <<< FRAC_BITS);
        w_sat64     = sat_trunc(w_sum64, WIDTH, FRAC_BITS);
        w_res       = w_sat64[WIDTH-1:0];
        w_unused_hi = ^w_sat64[NN_WIDE-1:WIDTH];
    end

    // Controller: state, tap/position counters, operand capture, result
    // write-back and the registered busy/done flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_oy    <= '0;
            r_ox    <= '0;
            r_ky    <= '0;
            r_kx    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bias  <= '0;
            for (int r = 0; r < INPUT_DIM_HEIGHT; r++) begin
                for (int c = 0; c < INPUT_DIM_WIDTH; c++) begin
                    r_in[r][c] <= '0;
                end
            end
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    r_k[r][c] <= '0;
                end
            end
            for (int r = 0; r < OUTPUT_DIM_HEIGHT; r++) begin
                for (int c = 0; c < OUTPUT_DIM_WIDTH; c++) begin
                    r_ofm[r][c] <= '0;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_in    <= input_feature_map;
                        r_k     <= kernel;
                        r_bias  <= bias;
                        r_oy    <= '0;
                        r_ox    <= '0;
                        r_ky    <= '0;
                        r_kx    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MAC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                MAC: begin
                    r_busy <= 1'b1;
                    r_done <= 1'b0;
                    if (r_kx == CW'(KERNEL_SIZE - 1)) begin
                        r_kx <= '0;
                        if (r_ky == RW'(KERNEL_SIZE - 1)) begin
                            r_ky    <= '0;
                            r_state <= WRITE;
                        end else begin
                            r_ky    <= r_ky + RW'(1);
                            r_state <= MAC;
                        end
                    end else begin
                        r_kx    <= r_kx + CW'(1);
                        r_state <= MAC;
                    end
                end
                WRITE: begin
                    r_ofm[r_oy][r_ox] <= w_res;
                    if (r_ox == CW'(OUTPUT_DIM_WIDTH - 1)) begin
                        r_ox <= '0;
                        if (r_oy == RW'(OUTPUT_DIM_HEIGHT - 1)) begin
                            r_oy    <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_oy    <= r_oy + RW'(1);
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_state <= MAC;
                        end
                    end else begin
                        r_ox    <= r_ox + CW'(1);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= MAC;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign output_feature_map = r_ofm;
    assign busy               = r_busy;
    assign done               = r_done;

endmodule

// File: tb/tb_conv_layer.sv
// Directed, self-checking bench for conv_layer with an expected-result
// scoreboard filled when each run is launched and drained on done.
module tb_conv_layer;

    logic clk;
    logic rst;
    logic start;
    logic signed [15:0] ifm  [0:3][0:3];
    logic signed [15:0] ker  [0:2][0:2];
    logic signed [15:0] bias;
    logic signed [15:0] ofm  [0:1][0:1];
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;
    logic signed [15:0] sb [$];

    conv_layer dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .input_feature_map  (ifm),
        .kernel             (ker),
        .bias               (bias),
        .output_feature_map (ofm),
        .busy               (busy),
        .done               (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: wide exact sum, floor shift, clamp to 16-bit range
    function automatic logic signed [15:0] model_px(input int oy, input int ox);
        longint acc;
        acc = 0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                acc += longint'(ifm[oy+ky][ox+kx]) * longint'(ker[ky][kx]);
            end
        end
        acc = acc + longint'(bias) * 256;
        acc = acc >>> 8;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    task automatic push_model();
        for (int oy = 0; oy < 2; oy++) begin
            for (int ox = 0; ox < 2; ox++) begin
                sb.push_back(model_px(oy, ox));
            end
        end
    endtask

    task automatic push_const(input int a, input int b, input int c, input int d);
        sb.push_back(16'(a));
        sb.push_back(16'(b));
        sb.push_back(16'(c));
        sb.push_back(16'(d));
    endtask

    task automatic fill(input int in_val, input int k_val, input int k_centre, input int b_val);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ifm[r][c] = 16'(in_val);
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                ker[r][c] = 16'(k_val);
            end
        end
        ker[1][1] = 16'(k_centre);
        bias = 16'(b_val);
    endtask

    task automatic rand_inputs();
        int t;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t = int'($urandom_range(0, 2047)) - 1024;
                ifm[r][c] = 16'(t);
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                t = int'($urandom_range(0, 2047)) - 1024;
                ker[r][c] = 16'(t);
            end
        end
        t = int'($urandom_range(0, 511)) - 256;
        bias = 16'(t);
    endtask

    task automatic compare_outputs(input string tag);
        logic signed [15:0] e;
        for (int oy = 0; oy < 2; oy++) begin
            for (int ox = 0; ox < 2; ox++) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL %s_sb_empty observed=0 expected=1", tag);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("%s_out%0d%0d", tag, oy, ox), ofm[oy][ox], e);
                end
            end
        end
    endtask

    // Launch a run, optionally pulse start with new operands mid-run,
    // check latency/busy/done, poke start on the DONE cycle, compare.
    task automatic run_and_wait(input string tag, input int glitch_edge);
        int edge_n;
        int busy_cnt;
        int done_cnt;
        int done_edge;
        int extra;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_edge = -1;
        start = 1'b1;
        tick();
        start  = 1'b0;
        edge_n = 0;
        if (busy) busy_cnt++;
        while (done_edge < 0 && edge_n < 200) begin
            tick();
            edge_n++;
            if (edge_n == glitch_edge) begin
                start = 1'b1;
                rand_inputs();
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_edge = edge_n;
            end
        end
        check({tag, "_done_edge"}, done_edge, 40);
        check({tag, "_busy_cycles"}, busy_cnt, 40);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_done_after"}, {31'd0, done}, 0);
        check({tag, "_busy_after"}, {31'd0, busy}, 0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy || done) extra++;
        end
        check({tag, "_idle_hold"}, extra, 0);
        compare_outputs(tag);
    endtask

    initial begin
        int activity;
        rst   = 1'b0;
        start = 1'b0;
        fill(0, 0, 0, 0);
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        for (int oy = 0; oy < 2; oy++) begin
            for (int ox = 0; ox < 2; ox++) begin
                check($sformatf("rst_out%0d%0d", oy, ox), ofm[oy][ox], 0);
            end
        end
        rst = 1'b1;
        tick();

        // Identity kernel
        fill(0, 0, 256, 0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ifm[r][c] = 16'(256 * (4 * r + c));
            end
        end
        push_const(1280, 1536, 2304, 2560);
        run_and_wait("ident", -1);

        // Summation with bias
        fill(256, 256, 256, 256);
        push_const(2560, 2560, 2560, 2560);
        run_and_wait("sum", -1);

        // Positive and negative saturation
        fill(25600, 256, 256, 0);
        push_const(32767, 32767, 32767, 32767);
        run_and_wait("satpos", -1);
        fill(25600, -256, -256, 0);
        push_const(-32768, -32768, -32768, -32768);
        run_and_wait("satneg", -1);

        // Floor on negative sums
        fill(1, 0, 1, -256);
        push_const(-256, -256, -256, -256);
        run_and_wait("trunc", -1);

        // Start while busy must not restart or recapture
        rand_inputs();
        push_model();
        run_and_wait("hs_busy", 10);

        // Fresh start from IDLE recomputes
        rand_inputs();
        push_model();
        run_and_wait("hs_fresh", -1);

        // Reset mid-run
        fill(256, 256, 256, 256);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
        for (int oy = 0; oy < 2; oy++) begin
            for (int ox = 0; ox < 2; ox++) begin
                check($sformatf("mid_rst_out%0d%0d", oy, ox), ofm[oy][ox], 0);
            end
        end
        activity = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy || done) activity++;
        end
        rst = 1'b1;
        tick();
        if (busy || done) activity++;
        check("mid_rst_quiet", activity, 0);
        rand_inputs();
        push_model();
        run_and_wait("after_rst", -1);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_layer.md
Name: conv_layer

Overview:
- Sequential 2D convolution stage sitting directly upstream of max_pool_layer; its output feeds max_pool_layer's input_feature_map.
- Uses one signed fixed-point MAC per cycle, stepping output positions in row-major order.
- Single channel, valid (no-padding) convolution, stride 1, scalar bias.
- A start/busy/done handshake lets the network controller sequence it ahead of pooling.

Parameters:
- WIDTH, 16, signed fixed-point word width.
- FRAC_BITS, 8, fractional bits (Q7.8 at defaults).
- INPUT_DIM_WIDTH, 4, input columns.
- INPUT_DIM_HEIGHT, 4, input rows.
- KERNEL_SIZE, 3, square kernel edge.
- OUTPUT_DIM_WIDTH, INPUT_DIM_WIDTH-KERNEL_SIZE+1, output columns (2).
- OUTPUT_DIM_HEIGHT, INPUT_DIM_HEIGHT-KERNEL_SIZE+1, output rows (2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  begin a convolution; sampled only in IDLE.
- input_feature_map  input  signed [WIDTH-1:0] [0:INPUT_DIM_HEIGHT-1][0:INPUT_DIM_WIDTH-1]  input activations.
- kernel  input  signed [WIDTH-1:0] [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1]  weights.
- bias  input  signed [WIDTH-1:0]  bias, same Q format.
- output_feature_map  output  signed [WIDTH-1:0] [0:OUTPUT_DIM_HEIGHT-1][0:OUTPUT_DIM_WIDTH-1]  convolution result, registered.
- busy  output  1  high in MAC and WRITE.
- done  output  1  one-cycle pulse when all outputs are valid.

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters, accumulator and operand registers cleared; output_feature_map all 0; busy=0; done=0.
- IDLE, start=1 at an edge:
  - Capture input_feature_map, kernel and bias into internal registers.
  - Clear oy, ox, ky, kx and acc; go to MAC.
  - Inputs may change after the capture edge without effect.
- MAC, each edge:
  - acc += in_reg[oy+ky][ox+kx] * k_reg[ky][kx], using the full 2*WIDTH-bit signed product.
  - kx increments and wraps into ky.
  - After the edge that processes ky=kx=KERNEL_SIZE-1, go to WRITE.
- Accumulator width: ACC_WIDTH = 2*WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE); it must never overflow.
- WRITE, one edge:
  - sum = acc + (bias <<< FRAC_BITS).
  - res = sum >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
  - Saturate res to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register into output_feature_map[oy][ox]; clear acc; advance ox, wrapping into oy.
  - If the last position was written, go to DONE; otherwise go to MAC.
- DONE: done=1 for exactly this cycle; go to IDLE on the next edge. start is ignored in DONE.
- Latency: the start-sampling edge is edge 0. DONE is entered at edge OH*OW*(K*K+1); at defaults this is edge 40, so done is high between edges 40 and 41.
- start while busy or in DONE: ignored; no restart and no recapture.
- Outputs hold their last values between runs. Entries are updated individually during a run; consumers read only after done.
- Reset mid-operation: immediate abort to the reset state; outputs are zeroed.
- busy is a Moore decode of state: high in MAC and WRITE, low in IDLE and DONE.

Decomposition:
- Shared package nn_pkg:
  - state enum (IDLE, MAC, WRITE, DONE);
  - function sat_trunc(acc) implementing the shift-and-saturate rule, for reuse by the fully-connected layer;
  - localparams for the default WIDTH and FRAC_BITS.
- Sub-module mac_unit: registered multiply-accumulate with clear and enable, parameterised by WIDTH and ACC_WIDTH. The FSM and index counters stay in conv_layer.

Test Plan:
- Identity: kernel centre = 256 (1.0), all other taps 0, bias 0; input[r][c] = 256*(4r+c). Expected output = [[1280,1536],[2304,2560]]; done on edge 40 after start; busy high for edges 1..40.
- Summation: all kernel taps and all inputs = 256, bias = 256. Every output = 2560 (10.0).
- Positive saturation: inputs = 25600 (100.0), kernel all 256. Every output = 32767. Negative case with kernel all -256 gives every output = -32768.
- Truncation: input all 1, kernel centre = 1, bias = -256. Expected output = (1-65536)>>>8 = -256 everywhere, which checks floor behaviour on negative sums.
- Handshake: pulse start again at edge 10 with different inputs. Results still reflect the first operands and done pulses once only. start asserted on the DONE cycle is ignored. A new start from IDLE recomputes correctly.
- Reset mid-run: drop rst at edge 20. Outputs go to 0 and busy and done go to 0 immediately, with no done pulse. After rst is released, a fresh start completes in 40 edges.
